scan_pattern_engine: RTL and testbench

- On-chip scan test sequencer, the parametrised successor to the chip-level ATPG chain bench flow.
- Drives NCHAIN parallel scan chains of CHAIN_LEN flops with streamed load data and applies capture cycles.
- Unloads each chain and compares the result against streamed expected data under a mask.
- Sits between the test-mode controller (TST/I2C register access) and the scan-inserted core; reports pass/fail, error count and first-fail location.

---
 rtl/scan_pattern_engine.sv | 189 ++++++++++++++++++
 tb/tb_scan_pattern_engine.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/scan_pattern_engine.sv
// scan_pattern_engine: on-chip scan sequencer. It streams load data into NCHAIN
// parallel chains, applies CAP_CYC capture cycles for each pattern, and compares
// the unloaded data against the expected stream under a mask.
// Optional build macro SCAN_DIAG_EN adds the first-fail diagnostic registers
// (ff_pat/ff_chain/ff_bit). When the macro is undefined, those outputs are tied to 0.
module scan_pattern_engine #(
    parameter int NCHAIN    = 4,
    parameter int CHAIN_LEN = 64,
    parameter int NPAT_W    = 12,
    parameter int CAP_CYC   = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              srstz,
    input  logic              start,
    input  logic              abort,
    input  logic [NPAT_W-1:0] npat,
    input  logic              si_valid,
    output logic              si_ready,
    input  logic [NCHAIN-1:0] si_data,
    input  logic [NCHAIN-1:0] si_exp,
    input  logic [NCHAIN-1:0] si_msk,
    output logic              scan_en,
    output logic              shift_en,
    output logic [NCHAIN-1:0] scan_in,
    input  logic [NCHAIN-1:0] scan_out,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [NPAT_W-1:0] ff_pat,
    output logic [4:0]        ff_chain,
    output logic [11:0]       ff_bit
);
    localparam int BW    = $clog2(CHAIN_LEN);
    localparam int PCW   = $clog2(NCHAIN + 1);
    localparam int SUM_W = ((CNT_W > PCW) ? CNT_W : PCW) + 1;
    localparam logic [BW-1:0]    LAST_BEAT = BW'(CHAIN_LEN - 1);
    localparam logic [2:0]       LAST_CAP  = 3'(CAP_CYC - 1);
    localparam logic [NPAT_W:0]  ONE_P     = (NPAT_W + 1)'(1);
    localparam logic [SUM_W-1:0] SAT_MAX   = SUM_W'({CNT_W{1'b1}});

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CAPTURE, S_UNLOAD, S_DONE} state_t;

    state_t            state;
    logic [BW-1:0]     beat;
    logic [2:0]        cap_cnt;
    logic [NPAT_W-1:0] pat_idx;
    logic [NPAT_W-1:0] npat_q;
    logic [NCHAIN-1:0] scan_in_q;
    logic [NCHAIN-1:0] mism;
    logic [PCW-1:0]    mism_cnt;
    logic [SUM_W-1:0]  err_sum;
    logic [NPAT_W:0]   pat_nxt;
    logic              accept;
    logic              cmp_act;

    // Handshake and chain controls decode straight from the state register.
    assign si_ready = (state == S_LOAD) || (state == S_UNLOAD);
    assign accept   = si_valid && si_ready;
    assign scan_en  = (state != S_CAPTURE);
    assign shift_en = accept || (state == S_CAPTURE);
    assign busy     = (state == S_LOAD) || (state == S_CAPTURE) || (state == S_UNLOAD);
    assign scan_in  = (state == S_UNLOAD) ? '0 :
                      ((state == S_LOAD) && accept) ? si_data : scan_in_q;

    // In LOAD, the chain tails still hold the previous pattern, so there is nothing to check for the first pattern.
    assign cmp_act  = accept && (((state == S_LOAD) && (pat_idx != '0)) || (state == S_UNLOAD));
    assign mism     = (scan_out ^ si_exp) & ~si_msk;
    assign pat_nxt  = {1'b0, pat_idx} + ONE_P;
    assign err_sum  = SUM_W'(err_cnt) + SUM_W'(mism_cnt);

    // Count the miscompares in this beat so they can be added to the error counter.
    always_comb begin
        mism_cnt = '0;
        for (int i = 0; i < NCHAIN; i++) mism_cnt = mism_cnt + PCW'(mism[i]);
    end

    // Sequencer: load, capture and unload, with beat, capture and pattern counters.
    always_ff @(posedge clk) begin
        if (!srstz) begin
            state     <= S_IDLE;
            beat      <= '0;
            cap_cnt   <= '0;
            pat_idx   <= '0;
            npat_q    <= '0;
            scan_in_q <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state   <= S_IDLE;
                beat    <= '0;
                cap_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        state   <= S_LOAD;
                        beat    <= '0;
                        cap_cnt <= '0;
                        pat_idx <= '0;
                        npat_q  <= npat;
                    end
                    S_LOAD: if (accept) begin
                        scan_in_q <= si_data;
                        if (beat == LAST_BEAT) begin
                            beat  <= '0;
                            state <= (npat_q != '0) ? S_CAPTURE : S_UNLOAD;
                        end else begin
                            beat <= beat + BW'(1);
                        end
                    end
                    S_CAPTURE: if (cap_cnt == LAST_CAP) begin
                        cap_cnt <= '0;
                        beat    <= '0;
                        pat_idx <= pat_nxt[NPAT_W-1:0];
                        state   <= (pat_nxt < {1'b0, npat_q}) ? S_LOAD : S_UNLOAD;
                    end else begin
                        cap_cnt <= cap_cnt + 3'd1;
                    end
                    S_UNLOAD: begin
                        scan_in_q <= '0;
                        if (accept) begin
                            if (beat == LAST_BEAT) begin
                                beat  <= '0;
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                beat <= beat + BW'(1);
                            end
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Sticky fail flag and saturating error count. A beat taken while abort is high is not counted.
    always_ff @(posedge clk) begin
        if (!srstz) begin
            fail    <= 1'b0;
            err_cnt <= '0;
        end else if ((state == S_IDLE) && start && !abort) begin
            fail    <= 1'b0;
            err_cnt <= '0;
        end else if (cmp_act && !abort) begin
            if (|mism) fail <= 1'b1;
            err_cnt <= (err_sum > SAT_MAX) ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
        end
    end

`ifdef SCAN_DIAG_EN
    logic [4:0]        low_idx;
    logic [NPAT_W-1:0] unl_idx;

    // Find the lowest failing chain, and the unload index that the current beat belongs to.
    always_comb begin
        low_idx = '0;
        for (int i = NCHAIN - 1; i >= 0; i--) if (mism[i]) low_idx = 5'(i);
        if (state == S_LOAD)     unl_idx = pat_idx - NPAT_W'(1);
        else if (npat_q != '0)   unl_idx = npat_q - NPAT_W'(1);
        else                     unl_idx = '0;
    end

    // Latch only the first failure after start; the fail flag being clear marks "first".
    always_ff @(posedge clk) begin
        if (!srstz) begin
            ff_pat   <= '0;
            ff_chain <= '0;
            ff_bit   <= '0;
        end else if ((state == S_IDLE) && start && !abort) begin
            ff_pat   <= '0;
            ff_chain <= '0;
            ff_bit   <= '0;
        end else if (cmp_act && !abort && (|mism) && !fail) begin
            ff_pat   <= unl_idx;
            ff_chain <= low_idx;
            ff_bit   <= 12'(beat);
        end
    end
`else
    assign ff_pat   = '0;
    assign ff_chain = '0;
    assign ff_bit   = '0;
`endif

endmodule

// File: tb/tb_scan_pattern_engine.sv
// Bench for scan_pattern_engine. It models the scan chains as shift registers,
// and each capture cycle inverts the chain contents. The expected unload stream
// is derived from the data the bench itself loaded.
module tb_scan_pattern_engine;
    localparam int N      = 4;
    localparam int L      = 8;
    localparam int NPAT_W = 12;
    localparam int CNT_W  = 4;
`ifdef SCAN_DIAG_EN
    localparam bit DIAG = 1'b1;
`else
    localparam bit DIAG = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              srstz = 1'b0, start = 1'b0, abort = 1'b0, si_valid = 1'b0;
    logic [NPAT_W-1:0] npat = '0;
    logic [N-1:0]      si_data = '0, si_exp = '0, si_msk = '0;
    logic              si_ready, scan_en, shift_en, busy, done, fail;
    logic [N-1:0]      scan_in, scan_out;
    logic [CNT_W-1:0]  err_cnt;
    logic [NPAT_W-1:0] ff_pat;
    logic [4:0]        ff_chain;
    logic [11:0]       ff_bit;

    scan_pattern_engine #(.NCHAIN(N), .CHAIN_LEN(L), .NPAT_W(NPAT_W), .CAP_CYC(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .srstz(srstz), .start(start), .abort(abort), .npat(npat),
        .si_valid(si_valid), .si_ready(si_ready), .si_data(si_data), .si_exp(si_exp),
        .si_msk(si_msk), .scan_en(scan_en), .shift_en(shift_en), .scan_in(scan_in),
        .scan_out(scan_out), .busy(busy), .done(done), .fail(fail), .err_cnt(err_cnt),
        .ff_pat(ff_pat), .ff_chain(ff_chain), .ff_bit(ff_bit));

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int n_shift, n_cap, n_done, n_stall0;
    logic [N-1:0] sb[$];
    logic [N-1:0] ld [0:3][0:L-1];
    logic [N-1:0][L-1:0] chain = '0;

    // The scan chain model: shift toward the tail in shift mode; capture inverts every flop.
    always @(posedge clk) begin
        if (shift_en) begin
            for (int i = 0; i < N; i++) begin
                if (scan_en) chain[i] <= {chain[i][L-2:0], scan_in[i]};
                else         chain[i] <= ~chain[i];
            end
        end
    end

    always_comb begin
        scan_out = '0;
        for (int i = 0; i < N; i++) scan_out[i] = chain[i][L-1];
    end

    // Monitor: pop the expected scan_in value for each shift, and count captures and done pulses.
    always @(negedge clk) begin
        logic [N-1:0] e;
        if (srstz && shift_en && scan_en) begin
            n_shift++;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scan_in_sb: shift with no expected beat queued (scan_in=%h)", scan_in);
            end else begin
                e = sb.pop_front();
                if (scan_in !== e) begin
                    n_fail++;
                    $display("FAIL scan_in_sb: got %h expected %h", scan_in, e);
                end
            end
        end
        if (srstz && shift_en && !scan_en) n_cap++;
        if (done) n_done++;
    end

    // The stimulus driver. Negative arguments disable an option. fs/fb/fn/fm flip the expected bits
    // on stream fs for beats fb..fb+fn-1, and mm masks those beats. stb/stn stall stream 0.
    // abb aborts on stream 0 at that beat. rsb resets on the last stream at that beat.
    task automatic run_scan(input int np, input int fs, input int fb, input int fn,
                            input logic [N-1:0] fm, input logic [N-1:0] mm,
                            input int stb, input int stn, input int abb, input int rsb);
        int nload, nstr, total, acc, s, k, cyc, stall_left;
        bit stalling, fin;
        nload = (np > 0) ? np : 1;
        nstr  = nload + 1;
        total = nstr * L;
        for (int p = 0; p < nload; p++)
            for (int b = 0; b < L; b++) ld[p][b] = N'($urandom);
        sb.delete();
        n_shift = 0; n_cap = 0; n_done = 0; n_stall0 = 0;
        @(posedge clk); #1;
        npat = NPAT_W'(np);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        acc = 0; cyc = 0; stall_left = stn; fin = 1'b0;
        while (!fin) begin
            s = acc / L;
            k = acc % L;
            stalling = (stb >= 0) && (s == 0) && (k == stb) && (stall_left > 0);
            if (stalling) stall_left--;
            si_valid = !stalling;
            start    = stalling;
            si_data  = (s < nload) ? ld[s][k] : N'($urandom);
            if (s == 0 || s >= nstr) si_exp = N'($urandom);
            else if (np > 0)         si_exp = ~ld[s-1][k];
            else                     si_exp = ld[0][k];
            si_msk = '0;
            if (s == fs && k >= fb && k < fb + fn) begin
                si_exp = si_exp ^ fm;
                si_msk = mm;
            end
            abort = (abb >= 0) && (s == 0) && (k == abb);
            srstz = !((rsb >= 0) && (s == nstr - 1) && (k == rsb));
            if (si_valid && si_ready && srstz) sb.push_back((s < nload) ? si_data : N'(0));
            @(negedge clk);
            if (stalling && !shift_en) n_stall0++;
            if (si_valid && si_ready) acc++;
            if (abort || !srstz) fin = 1'b1;
            if (acc >= total && !busy && !done) fin = 1'b1;
            cyc++;
            if (cyc > 500) begin
                n_tests++; n_fail++;
                $display("FAIL run_timeout: %0d beats accepted of %0d after %0d cycles", acc, total, cyc);
                fin = 1'b1;
            end
            @(posedge clk); #1;
        end
        abort = 1'b0; start = 1'b0; si_valid = 1'b0;
    endtask

    task automatic test_reset;
        srstz = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (scan_en !== 1'b1) begin n_fail++; $display("FAIL reset_scan_en: got %b expected 1", scan_en); end
        n_tests++; if ({busy, done, si_ready, shift_en} !== 4'b0) begin n_fail++; $display("FAIL reset_ctl: busy/done/ready/shift=%b expected 0000", {busy, done, si_ready, shift_en}); end
        n_tests++; if ({fail, err_cnt, scan_in} !== '0) begin n_fail++; $display("FAIL reset_status: fail=%b err=%0d scan_in=%h expected 0", fail, err_cnt, scan_in); end
        n_tests++; if ({ff_pat, ff_chain, ff_bit} !== '0) begin n_fail++; $display("FAIL reset_diag: %h/%h/%h expected 0", ff_pat, ff_chain, ff_bit); end
        srstz = 1'b1;
    endtask

    task automatic test_clean;
        run_scan(2, -1, 0, 0, '0, '0, -1, 0, -1, -1);
        n_tests++; if (n_shift != 24) begin n_fail++; $display("FAIL clean_beats: got %0d expected 24", n_shift); end
        n_tests++; if (n_cap != 2) begin n_fail++; $display("FAIL clean_capture: got %0d expected 2", n_cap); end
        n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL clean_done: got %0d pulses expected 1", n_done); end
        n_tests++; if (fail !== 1'b0 || err_cnt !== 4'd0) begin n_fail++; $display("FAIL clean_status: fail=%b err=%0d expected 0/0", fail, err_cnt); end
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL clean_sb_left: %0d beats not shifted, expected 0", sb.size()); end
    endtask

    task automatic test_miscompare;
        logic [NPAT_W-1:0] ep; logic [4:0] ec; logic [11:0] eb;
        ep = DIAG ? NPAT_W'(1) : '0; ec = DIAG ? 5'd2 : 5'd0; eb = DIAG ? 12'd5 : 12'd0;
        run_scan(2, 2, 5, 1, 4'b0100, 4'b0000, -1, 0, -1, -1);
        n_tests++; if (err_cnt !== 4'd1 || fail !== 1'b1) begin n_fail++; $display("FAIL mis_status: err=%0d fail=%b expected 1/1", err_cnt, fail); end
        n_tests++; if (ff_pat !== ep || ff_chain !== ec || ff_bit !== eb) begin n_fail++; $display("FAIL mis_diag: pat=%0d chain=%0d bit=%0d expected %0d/%0d/%0d", ff_pat, ff_chain, ff_bit, ep, ec, eb); end
    endtask

    task automatic test_mask;
        run_scan(2, 2, 5, 1, 4'b0100, 4'b0100, -1, 0, -1, -1);
        n_tests++; if (err_cnt !== 4'd0 || fail !== 1'b0) begin n_fail++; $display("FAIL mask_status: err=%0d fail=%b expected 0/0", err_cnt, fail); end
        n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL mask_done: got %0d expected 1", n_done); end
    endtask

    task automatic test_stall;
        run_scan(2, -1, 0, 0, '0, '0, 4, 3, -1, -1);
        n_tests++; if (n_stall0 != 3) begin n_fail++; $display("FAIL stall_shift_off: got %0d cycles expected 3", n_stall0); end
        n_tests++; if (n_shift != 24 || n_done != 1) begin n_fail++; $display("FAIL stall_beats: beats=%0d done=%0d expected 24/1", n_shift, n_done); end
        n_tests++; if (err_cnt !== 4'd0 || fail !== 1'b0) begin n_fail++; $display("FAIL stall_status: err=%0d fail=%b expected 0/0", err_cnt, fail); end
    endtask

    task automatic test_flush;
        logic [4:0] ec; logic [11:0] eb;
        ec = DIAG ? 5'd1 : 5'd0; eb = DIAG ? 12'd7 : 12'd0;
        run_scan(0, 1, 7, 1, 4'b0010, 4'b0000, -1, 0, -1, -1);
        n_tests++; if (n_shift != 16 || n_cap != 0) begin n_fail++; $display("FAIL flush_beats: beats=%0d caps=%0d expected 16/0", n_shift, n_cap); end
        n_tests++; if (err_cnt !== 4'd1 || fail !== 1'b1) begin n_fail++; $display("FAIL flush_status: err=%0d fail=%b expected 1/1", err_cnt, fail); end
        n_tests++; if (ff_pat !== '0 || ff_chain !== ec || ff_bit !== eb) begin n_fail++; $display("FAIL flush_diag: pat=%0d chain=%0d bit=%0d expected 0/%0d/%0d", ff_pat, ff_chain, ff_bit, ec, eb); end
    endtask

    task automatic test_abort;
        run_scan(2, -1, 0, 0, '0, '0, -1, 0, 3, -1);
        n_tests++; if (busy !== 1'b0 || scan_en !== 1'b1 || shift_en !== 1'b0) begin n_fail++; $display("FAIL abort_state: busy=%b scan_en=%b shift_en=%b expected 0/1/0", busy, scan_en, shift_en); end
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (n_done != 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses expected 0", n_done); end
        run_scan(2, -1, 0, 0, '0, '0, -1, 0, -1, -1);
        n_tests++; if (err_cnt !== 4'd0 || fail !== 1'b0 || n_done != 1) begin n_fail++; $display("FAIL abort_rerun: err=%0d fail=%b done=%0d expected 0/0/1", err_cnt, fail, n_done); end
    endtask

    task automatic test_saturate;
        logic [NPAT_W-1:0] ep;
        ep = DIAG ? NPAT_W'(1) : '0;
        run_scan(2, 2, 0, 5, 4'hF, 4'h0, -1, 0, -1, -1);
        n_tests++; if (err_cnt !== 4'd15 || fail !== 1'b1) begin n_fail++; $display("FAIL sat_status: err=%0d fail=%b expected 15/1", err_cnt, fail); end
        n_tests++; if (ff_pat !== ep || ff_chain !== 5'd0 || ff_bit !== 12'd0) begin n_fail++; $display("FAIL sat_diag: pat=%0d chain=%0d bit=%0d expected %0d/0/0", ff_pat, ff_chain, ff_bit, ep); end
    endtask

    task automatic test_reset_mid;
        run_scan(0, 1, 0, 1, 4'hF, 4'h0, -1, 0, -1, 3);
        n_tests++; if (scan_en !== 1'b1 || {busy, done, si_ready, shift_en} !== 4'b0) begin n_fail++; $display("FAIL rstmid_ctl: scan_en=%b busy/done/ready/shift=%b expected 1/0000", scan_en, {busy, done, si_ready, shift_en}); end
        n_tests++; if ({fail, err_cnt, scan_in, ff_pat, ff_chain, ff_bit} !== '0) begin n_fail++; $display("FAIL rstmid_status: fail=%b err=%0d scan_in=%h diag=%h/%h/%h expected 0", fail, err_cnt, scan_in, ff_pat, ff_chain, ff_bit); end
        srstz = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_miscompare();
        test_mask();
        test_stall();
        test_flush();
        test_abort();
        test_saturate();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
